// File: rtl/auth_session_ctrl_pkg.sv
// rtl/auth_session_ctrl_pkg.sv - session sequencer states, defaults and authenticator status encodings
package auth_session_ctrl_pkg;

  localparam int unsigned DEF_NUM_ACCOUNTS   = 10;
  localparam int unsigned DEF_MAX_TRIES      = 3;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000;
  localparam int unsigned IDX_W              = 4;
  localparam int unsigned PIN_W              = 16;

  typedef logic [2:0] auth_state_t;

  localparam auth_state_t S_IDLE     = 3'd0;
  localparam auth_state_t S_LOOKUP   = 3'd1;
  localparam auth_state_t S_WAIT_PIN = 3'd2;
  localparam auth_state_t S_CHECK    = 3'd3;
  localparam auth_state_t S_ACTIVE   = 3'd4;

  localparam logic [1:0] ACCOUNT_FOUND         = 2'b01;
  localparam logic [1:0] ACCOUNT_AUTHENTICATED = 2'b10;

  function automatic logic [1:0] pack_status(input logic found, input logic ok);
    return {ok, found};
  endfunction

endpackage

// File: rtl/auth_session_ctrl_session_timer.sv
// rtl/auth_session_ctrl_session_timer.sv - inactivity counter for the timed session states
module auth_session_ctrl_session_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Held at zero outside the timed states, so every entry starts a fresh count.
  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (!enable || clear) count_d = '0;
  end

  assign expired = enable && !clear && (count_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/auth_session_ctrl.sv
// rtl/auth_session_ctrl.sv - card/PIN session sequencer with per-account lockout and inactivity timeout
module auth_session_ctrl
  import auth_session_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ACCOUNTS   = DEF_NUM_ACCOUNTS,
  parameter int unsigned MAX_TRIES      = DEF_MAX_TRIES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             card_valid,
  input  logic [IDX_W-1:0] card_acc_num,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin_in,
  input  logic             user_activity,
  input  logic             logout,
  input  logic             admin_unlock,
  input  logic [IDX_W-1:0] unlock_index,
  output logic [IDX_W-1:0] auth_acc_num,
  output logic [PIN_W-1:0] auth_pin,
  input  logic [IDX_W-1:0] auth_acc_index,
  input  logic             auth_found,
  input  logic             auth_ok,
  output logic             session_active,
  output logic [IDX_W-1:0] session_index,
  output logic [1:0]       tries_left,
  output logic             card_reject,
  output logic             pin_reject,
  output logic             acct_locked,
  output logic             timeout_evt
);

  auth_state_t             state_q, state_d;
  logic [IDX_W-1:0]        acc_q, acc_d, index_q, index_d;
  logic [PIN_W-1:0]        pin_q, pin_d;
  logic                    active_q, active_d;
  logic [1:0]              tries_q, tries_d;
  logic                    crej_q, crej_d, prej_q, prej_d, locked_q, locked_d, tmo_q, tmo_d;
  logic [NUM_ACCOUNTS-1:0] lock_q, lock_d;

  logic       expired, timer_en, timer_clr, to_idle, found, ok, idx_locked;
  logic [1:0] status;

  assign status     = pack_status(auth_found, auth_ok);
  assign found      = |(status & ACCOUNT_FOUND);
  assign ok         = |(status & ACCOUNT_AUTHENTICATED);
  assign idx_locked = (32'(auth_acc_index) < NUM_ACCOUNTS) && lock_q[auth_acc_index];
  assign timer_en   = (state_q == S_WAIT_PIN) || (state_q == S_ACTIVE);
  assign timer_clr  = user_activity || ((state_q == S_WAIT_PIN) && pin_valid);

  auth_session_ctrl_session_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .enable  (timer_en),
    .clear   (timer_clr),
    .expired (expired)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    pin_d    = pin_q;
    index_d  = index_q;
    active_d = active_q;
    tries_d  = tries_q;
    crej_d   = 1'b0;
    prej_d   = 1'b0;
    locked_d = 1'b0;
    tmo_d    = 1'b0;
    to_idle  = 1'b0;
    lock_d   = lock_q;
    // Unlock is applied first so a lock set by a failing CHECK overrides it.
    if (admin_unlock && (32'(unlock_index) < NUM_ACCOUNTS)) lock_d[unlock_index] = 1'b0;
    case (state_q)
      S_IDLE: if (card_valid) begin
        acc_d   = card_acc_num;
        pin_d   = '0;
        state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (!found) begin
          crej_d  = 1'b1;
          state_d = S_IDLE;
        end else if (idx_locked) begin
          locked_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          index_d = auth_acc_index;
          tries_d = 2'(MAX_TRIES);
          state_d = S_WAIT_PIN;
        end
      end
      S_WAIT_PIN: begin
        if (logout) to_idle = 1'b1;
        else if (pin_valid) begin
          pin_d   = pin_in;
          state_d = S_CHECK;
        end else if (expired) begin
          tmo_d   = 1'b1;
          to_idle = 1'b1;
        end
      end
      S_CHECK: begin
        if (ok) begin
          active_d = 1'b1;
          state_d  = S_ACTIVE;
        end else if (tries_q <= 2'd1) begin
          lock_d[index_q] = 1'b1;
          locked_d        = 1'b1;
          to_idle         = 1'b1;
        end else begin
          tries_d = tries_q - 2'd1;
          prej_d  = 1'b1;
          state_d = S_WAIT_PIN;
        end
      end
      S_ACTIVE: begin
        if (logout) to_idle = 1'b1;
        else if (expired) begin
          tmo_d   = 1'b1;
          to_idle = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (to_idle) begin
      state_d  = S_IDLE;
      active_d = 1'b0;
      tries_d  = 2'd0;
      pin_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      pin_q    <= '0;
      index_q  <= '0;
      active_q <= 1'b0;
      tries_q  <= 2'd0;
      crej_q   <= 1'b0;
      prej_q   <= 1'b0;
      locked_q <= 1'b0;
      tmo_q    <= 1'b0;
      lock_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      pin_q    <= pin_d;
      index_q  <= index_d;
      active_q <= active_d;
      tries_q  <= tries_d;
      crej_q   <= crej_d;
      prej_q   <= prej_d;
      locked_q <= locked_d;
      tmo_q    <= tmo_d;
      lock_q   <= lock_d;
    end
  end

  assign auth_acc_num   = acc_q;
  assign auth_pin       = pin_q;
  assign session_active = active_q;
  assign session_index  = index_q;
  assign tries_left     = tries_q;
  assign card_reject    = crej_q;
  assign pin_reject     = prej_q;
  assign acct_locked    = locked_q;
  assign timeout_evt    = tmo_q;

endmodule
